sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Produces the SHA-256 message schedule W[0..63] for one 512-bit block. It accepts 16 big-endian 32-bit message words, then emits 64 schedule words in order through a valid/ready stream. It is the operand producer for the round datapath's 3-input modular adders (alpha3_1adder and similar), which consume W[t] each round. It replaces any combinational W expansion with a 16-entry sliding window and one expansion adder tree.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; must be at least 16 and at most 64 (index width 6).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  message word valid
in_ready  output  1  block accepts message word (high only in LOAD)
in_data  input  32  message word, M[0] first
w_valid  output  1  schedule word valid (high only in EMIT)
w_ready  input  1  downstream accepts schedule word
w_data  output  32  schedule word W[t]
w_index  output  6  t of the word on w_data
w_last  output  1  high with w_valid when t = ROUNDS-1

Behaviour:
- One clock and one reset: clk; synchronous active-high reset. All state updates on the rising edge of clk.
- Reset: state = LOAD, count = 0, window win[0..15] = 0. Output values after reset: in_ready = 1, w_valid = 0, w_data = 0, w_index = 0, w_last = 0.
- Handshake: a transfer occurs on a cycle with valid && ready. Outputs are driven from registers or decoded from state only; there is no combinational path from in_valid or w_ready to any output.
- State LOAD:
  - in_ready = 1; w_valid = 0.
  - On each input transfer: win[count] <= in_data; count <= count + 1.
  - On the transfer with count = 15: state <= EMIT and count <= 0, so w_valid rises the next cycle.
  - in_valid low: hold state, no change.
- State EMIT:
  - in_ready = 0 (in_valid is ignored); w_valid = 1; w_data = win[0]; w_index = count; w_last = (count == ROUNDS-1).
  - On each output transfer, shift the window: win[i] <= win[i+1] for i = 0..14, and win[15] <= new.
  - new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32, with carries out of bit 31 discarded.
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Window invariant: win[0..15] holds W[t..t+15] when count = t. Words 0..15 therefore pass through unchanged.
  - count <= count + 1 per transfer. On the transfer with w_last = 1: state <= LOAD, count <= 0, and in_ready is high the next cycle.
  - w_ready low: data, index and window hold stable while w_valid stays high (no-drop, no-duplicate).
- Latency and throughput:
  - Minimum 16 cycles to load and ROUNDS cycles to emit.
  - First w_valid one cycle after the 16th input transfer.
  - Back-to-back blocks give 80 cycles per block at ROUNDS = 64.
  - No overlap of load and emit.
- Boundary conditions:
  - Reset asserted mid-LOAD or mid-EMIT aborts the block: the partial block is discarded and the reset values above apply the next cycle.
  - Reset has priority over a simultaneous transfer.
  - w_index never exceeds ROUNDS-1.
  - The expansion sum wraps mod 2^32.
- Expansion arithmetic: implement as two chained 3-input-style additions, sum0 = sigma1 + win[9], then out = sum0 + sigma0 + win[0], all 32-bit truncated. Single cycle; no pipelining of the window.

Test Plan:
- "abc" block: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, w_ready tied 1 -> W[0..15] echo the inputs; W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405. w_last is high only at w_index = 63, and in_ready rises the following cycle.
- All words 0xFFFFFFFF -> W16 = 0x203FFFFC (mod-2^32 wrap check). Remaining words must match the reference model.
- All-zero block -> 64 words of 0x00000000 with w_index 0..63 contiguous, no gaps or repeats.
- Random w_ready stalls (about 50% low) and random in_valid gaps on random blocks -> output sequence identical to the stall-free golden model. w_data and w_index stay stable while stalled.
- Reset pulsed after 7 loaded words, then again at w_index = 30 -> w_valid = 0 and in_ready = 1 the next cycle. A fresh full block then emits from w_index 0 with correct values.
- Two back-to-back blocks with in_valid held high -> second block load starts the cycle after the first w_last transfer. Both schedules are correct; total 160 cycles.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// Stream bundle for the SHA-256 message schedule.
// The message-word input and the schedule-word output share one interface.
// The schedule block uses the slave view. The feeder/consumer uses the master view.
interface sha256_msg_schedule_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_index;
    logic        w_last;

    modport slave (
        input  in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, w_index, w_last
    );

    modport master (
        output in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, w_index, w_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
// Loads 16 message words into a 16-entry sliding window, then emits W[0..ROUNDS-1].
// One new word is appended per output transfer, produced by a single expansion adder tree.
// Outputs are decoded from state and registers only, so there is no path from
// in_valid or w_ready to any output.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sha256_msg_schedule_if.slave  bus
);

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_count;
    logic [31:0] r_win [16];

    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_last_word;
    logic [31:0] w_sum0;
    logic [31:0] w_new;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_in_xfer   = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_xfer  = (r_state == S_EMIT) && bus.w_ready;
    assign w_last_word = (r_count == LAST_IDX);

    // Expansion is two chained additions; the 32-bit truncation discards carries out of bit 31.
    assign w_sum0 = f_sigma1(r_win[14]) + r_win[9];
    assign w_new  = w_sum0 + f_sigma0(r_win[1]) + r_win[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream outputs. Output data is forced to zero outside EMIT.
    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = 1'b0;
        bus.w_valid  = 1'b0;
        bus.w_data   = '0;
        bus.w_index  = '0;
        bus.w_last   = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (r_count == 6'd15)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                bus.w_valid = 1'b1;
                bus.w_data  = r_win[0];
                bus.w_index = r_count;
                bus.w_last  = w_last_word;
                if (bus.w_ready && w_last_word) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Word counter: the load slot in LOAD, and the schedule index t in EMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_in_xfer) begin
            r_count <= (r_count == 6'd15) ? 6'd0 : r_count + 6'd1;
        end else if (w_out_xfer) begin
            r_count <= w_last_word ? 6'd0 : r_count + 6'd1;
        end
    end

    // Sliding window. In EMIT, win[0..15] holds W[t..t+15]; it shifts by one word per output transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_in_xfer) begin
            r_win[r_count[3:0]] <= bus.in_data;
        end else if (w_out_xfer) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule.
// Includes known-answer vectors, random blocks with stalls and gaps,
// reset aborts, and back-to-back blocks.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];
    typedef struct {
        blk_t        m;
        int          n_known;
        logic [31:0] w16;
        logic [31:0] w17;
        logic [31:0] w18;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    sha256_msg_schedule_if u_if();

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic ref_sched(input blk_t m, output sch_t w);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else        w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rand_blk(output blk_t m);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    task automatic load_block(input blk_t m, input int nw, input int gap_pct, input bit hold_valid);
        int i = 0;
        int guard = 0;
        bit v;
        bit r;
        while (i < nw && guard < 2000) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            u_if.in_valid = v;
            u_if.in_data  = m[i];
            r = u_if.in_ready;
            tick;
            guard++;
            if (v && r) i++;
        end
        u_if.in_valid = hold_valid;
        if (i < nw) chk("load_timeout", i, nw);
    endtask

    task automatic emit_block(input sch_t exp, input int stall_pct, input int stop_at, output sch_t got);
        int t = 0;
        int guard = 0;
        bit v;
        bit r;
        while (t < stop_at && guard < 4000) begin
            v = u_if.w_valid;
            chk($sformatf("w_valid t=%0d", t), v, 1);
            if (v) begin
                chk($sformatf("w_index t=%0d", t), u_if.w_index, t);
                chk($sformatf("w_data t=%0d", t), u_if.w_data, exp[t]);
                chk($sformatf("w_last t=%0d", t), u_if.w_last, (t == ROUNDS - 1));
                chk($sformatf("in_ready_emit t=%0d", t), u_if.in_ready, 0);
                got[t] = u_if.w_data;
            end
            r = ($urandom_range(0, 99) >= stall_pct);
            u_if.w_ready = r;
            tick;
            guard++;
            if (v && r) t++;
        end
        u_if.w_ready = 1'b0;
        if (t < stop_at) chk("emit_timeout", t, stop_at);
        if (stop_at == ROUNDS) begin
            chk("in_ready_after_last", u_if.in_ready, 1);
            chk("w_valid_after_last", u_if.w_valid, 0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs [3];
        blk_t m;
        blk_t mb;
        sch_t exp;
        sch_t expb;
        sch_t got;
        int   c0;

        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        u_if.w_ready  = 1'b0;

        // reset state
        reset = 1'b1;
        repeat (3) tick;
        chk("rst_in_ready", u_if.in_ready, 1);
        chk("rst_w_valid", u_if.w_valid, 0);
        chk("rst_w_data", u_if.w_data, 0);
        chk("rst_w_index", u_if.w_index, 0);
        chk("rst_w_last", u_if.w_last, 0);
        reset = 1'b0;
        tick;
        chk("idle_in_ready", u_if.in_ready, 1);
        chk("idle_w_valid", u_if.w_valid, 0);

        // known-answer table
        for (int i = 0; i < 16; i++) vecs[0].m[i] = 32'h0;
        vecs[0].m[0]  = 32'h61626380;
        vecs[0].m[15] = 32'h00000018;
        vecs[0].n_known = 3;
        vecs[0].w16 = 32'h61626380;
        vecs[0].w17 = 32'h000F0000;
        vecs[0].w18 = 32'h7DA86405;
        for (int i = 0; i < 16; i++) vecs[1].m[i] = 32'hFFFFFFFF;
        vecs[1].n_known = 1;
        vecs[1].w16 = 32'h203FFFFC;
        vecs[1].w17 = 32'h0;
        vecs[1].w18 = 32'h0;
        for (int i = 0; i < 16; i++) vecs[2].m[i] = 32'h0;
        vecs[2].n_known = 3;
        vecs[2].w16 = 32'h0;
        vecs[2].w17 = 32'h0;
        vecs[2].w18 = 32'h0;

        for (int k = 0; k < 3; k++) begin
            ref_sched(vecs[k].m, exp);
            load_block(vecs[k].m, 16, 0, 1'b0);
            emit_block(exp, 0, ROUNDS, got);
            chk($sformatf("vec%0d_w16", k), got[16], vecs[k].w16);
            if (vecs[k].n_known >= 3) begin
                chk($sformatf("vec%0d_w17", k), got[17], vecs[k].w17);
                chk($sformatf("vec%0d_w18", k), got[18], vecs[k].w18);
            end
        end

        // random blocks with input gaps and output stalls
        for (int b = 0; b < 4; b++) begin
            rand_blk(m);
            ref_sched(m, exp);
            load_block(m, 16, 30, 1'b0);
            emit_block(exp, 50, ROUNDS, got);
        end

        // reset after 7 loaded words
        rand_blk(m);
        load_block(m, 7, 0, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_load_w_valid", u_if.w_valid, 0);
        chk("rst_load_in_ready", u_if.in_ready, 1);

        // reset at w_index 30, together with a pending transfer
        rand_blk(m);
        ref_sched(m, exp);
        load_block(m, 16, 0, 1'b0);
        emit_block(exp, 0, 30, got);
        chk("pre_rst_index", u_if.w_index, 30);
        u_if.w_ready = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        u_if.w_ready = 1'b0;
        chk("rst_emit_w_valid", u_if.w_valid, 0);
        chk("rst_emit_in_ready", u_if.in_ready, 1);
        chk("rst_emit_w_index", u_if.w_index, 0);
        chk("rst_emit_w_data", u_if.w_data, 0);

        // fresh block after the aborts
        rand_blk(m);
        ref_sched(m, exp);
        load_block(m, 16, 0, 1'b0);
        emit_block(exp, 0, ROUNDS, got);

        // two back-to-back blocks, in_valid held high
        rand_blk(m);
        rand_blk(mb);
        ref_sched(m, exp);
        ref_sched(mb, expb);
        c0 = cyc;
        load_block(m, 16, 0, 1'b1);
        emit_block(exp, 0, ROUNDS, got);
        load_block(mb, 16, 0, 1'b0);
        emit_block(expb, 0, ROUNDS, got);
        chk("b2b_cycles", cyc - c0, 160);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
